// File: rtl/instr_decode_if.sv
// Bus between program memory / sequencer and the instr_decode stage.
// Carries the instruction word in, and loop-setup plus FIR datapath controls out.
interface instr_decode_if #(
    parameter int PW = 16
);
    logic [31:0]   instr;
    logic          loop_we;
    logic [11:0]   loop_iter;
    logic [11:0]   loop_size;
    logic          mac_en;
    logic          acc_clr;
    logic          out_we;
    logic [PW-1:0] coef_addr;
    logic [PW-1:0] samp_addr;
    logic          halted;
    logic [1:0]    err;

    modport master (
        output instr,
        input  loop_we, loop_iter, loop_size, mac_en, acc_clr, out_we,
        input  coef_addr, samp_addr, halted, err
    );

    modport slave (
        input  instr,
        output loop_we, loop_iter, loop_size, mac_en, acc_clr, out_we,
        output coef_addr, samp_addr, halted, err
    );
endinterface

// File: rtl/instr_decode.sv
// FIR program decode stage: combinational loop setup, registered MAC/CLR/STORE pulses,
// coefficient and sample address generators. Define CIRC_ADDR_EN for circular sample addressing.
module instr_decode #(
    parameter int PW  = 16,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          reset,
    instr_decode_if.slave bus
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_LOOP  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_SETP  = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_SETL  = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_MAC   = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_CLR   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_STORE = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(4'h7);

    state_e        state_q, state_d;
    logic          mac_en_q, mac_en_d;
    logic          acc_clr_q, acc_clr_d;
    logic          out_we_q, out_we_d;
    logic [1:0]    err_q, err_d;
    // Pointers run one MAC ahead of the presented operand addresses.
    logic [PW-1:0] coef_ptr_q, coef_ptr_d;
    logic [PW-1:0] coef_addr_q, coef_addr_d;
    logic [PW-1:0] samp_ptr_q, samp_ptr_d;
    logic [PW-1:0] samp_addr_q, samp_addr_d;
`ifdef CIRC_ADDR_EN
    logic [PW-1:0] samp_base_q, samp_base_d;
    logic [PW-1:0] samp_len_q, samp_len_d;
`endif

    logic [OPW-1:0] opcode;
    logic [PW-1:0]  imm;
    logic [PW-1:0]  samp_next;
    logic           loop_we_c;
    logic           unused_instr_bits;

    assign opcode            = bus.instr[31:32-OPW];
    assign imm               = PW'(bus.instr[15:0]);
    assign unused_instr_bits = ^bus.instr[26:24];

`ifdef CIRC_ADDR_EN
    always_comb begin
        samp_next = samp_ptr_q + PW'(1);
        if (samp_len_q != '0 && samp_ptr_q == samp_base_q + samp_len_q - PW'(1)) begin
            samp_next = samp_base_q;
        end
    end
`else
    assign samp_next = samp_ptr_q + PW'(1);
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d     = state_q;
        mac_en_d    = 1'b0;
        acc_clr_d   = 1'b0;
        out_we_d    = 1'b0;
        err_d       = err_q;
        coef_ptr_d  = coef_ptr_q;
        coef_addr_d = coef_ptr_q;
        samp_ptr_d  = samp_ptr_q;
        samp_addr_d = samp_ptr_q;
        loop_we_c   = 1'b0;
`ifdef CIRC_ADDR_EN
        samp_base_d = samp_base_q;
        samp_len_d  = samp_len_q;
`endif

        if (state_q == S_RUN) begin
            case (opcode)
                OP_NOP: ;
                OP_LOOP: begin
                    loop_we_c = 1'b1;
                    if (bus.instr[23:12] == 12'd0) err_d[1] = 1'b1;
                end
                OP_SETP: begin
                    if (bus.instr[27]) begin
                        samp_ptr_d  = imm;
                        samp_addr_d = imm;
`ifdef CIRC_ADDR_EN
                        samp_base_d = imm;
`endif
                    end else begin
                        // The coefficient base has no later use, so the pointer alone holds it.
                        coef_ptr_d  = imm;
                        coef_addr_d = imm;
                    end
                end
                OP_SETL: begin
`ifdef CIRC_ADDR_EN
                    if (bus.instr[27]) samp_len_d = imm;
`endif
                end
                OP_MAC: begin
                    mac_en_d   = 1'b1;
                    coef_ptr_d = coef_ptr_q + PW'(1);
                    samp_ptr_d = samp_next;
                end
                OP_CLR:   acc_clr_d = 1'b1;
                OP_STORE: out_we_d  = 1'b1;
                OP_HALT:  state_d   = S_HALT;
                default:  err_d[0]  = 1'b1;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            mac_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            out_we_q    <= 1'b0;
            err_q       <= '0;
            coef_ptr_q  <= '0;
            coef_addr_q <= '0;
            samp_ptr_q  <= '0;
            samp_addr_q <= '0;
`ifdef CIRC_ADDR_EN
            samp_base_q <= '0;
            samp_len_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mac_en_q    <= mac_en_d;
            acc_clr_q   <= acc_clr_d;
            out_we_q    <= out_we_d;
            err_q       <= err_d;
            coef_ptr_q  <= coef_ptr_d;
            coef_addr_q <= coef_addr_d;
            samp_ptr_q  <= samp_ptr_d;
            samp_addr_q <= samp_addr_d;
`ifdef CIRC_ADDR_EN
            samp_base_q <= samp_base_d;
            samp_len_q  <= samp_len_d;
`endif
        end
    end

    // Loop setup must not reach the sequencer while reset holds the block.
    assign bus.loop_we   = reset && loop_we_c;
    assign bus.loop_iter = bus.instr[23:12];
    assign bus.loop_size = bus.instr[11:0];
    assign bus.mac_en    = mac_en_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.out_we    = out_we_q;
    assign bus.coef_addr = coef_addr_q;
    assign bus.samp_addr = samp_addr_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed program fragments plus random instruction
// streams, checked against a behavioural model of the decode rules (honours CIRC_ADDR_EN).
module tb_instr_decode;

    localparam int PW = 16;

    logic clk;
    logic reset;

    instr_decode_if #(.PW(PW)) bus ();

    instr_decode #(.PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        mac;
        logic        clr;
        logic        owe;
        logic        halted;
        logic [15:0] coef;
        logic [15:0] samp;
        logic [1:0]  err;
    } reg_exp_t;

    typedef struct {
        int          idx;
        logic        lwe;
        logic [11:0] iter;
        logic [11:0] size;
    } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];
    reg_exp_t  pend;
    bit        pend_valid;

    int checks   = 0;
    int failures = 0;
    int n_issued = 0;

    // Behavioural model state
    int       m_coef, m_samp;
    bit       m_halt;
    bit [1:0] m_err;
`ifdef CIRC_ADDR_EN
    int       m_base, m_len;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int samp_after(input int s);
`ifdef CIRC_ADDR_EN
        if (m_len != 0 && s == ((m_base + m_len - 1) & 16'hFFFF)) return m_base;
`endif
        return (s + 1) & 16'hFFFF;
    endfunction

    task automatic model_reset();
        m_coef = 0;
        m_samp = 0;
        m_halt = 1'b0;
        m_err  = 2'b00;
`ifdef CIRC_ADDR_EN
        m_base = 0;
        m_len  = 0;
`endif
    endtask

    // Drive one instruction for one cycle and queue what the DUT should show for it.
    task automatic issue(input logic [31:0] ins);
        reg_exp_t  r;
        comb_exp_t c;
        int        op, imm, old_coef, old_samp;
        bit        did_mac;
        @(posedge clk);
        #1;
        bus.instr = ins;
        op       = int'(ins[31:28]);
        imm      = int'(ins[15:0]);
        old_coef = m_coef;
        old_samp = m_samp;
        did_mac  = 1'b0;

        c.idx  = n_issued;
        c.lwe  = !m_halt && op == 1;
        c.iter = ins[23:12];
        c.size = ins[11:0];

        r.idx = n_issued;
        r.mac = 1'b0;
        r.clr = 1'b0;
        r.owe = 1'b0;
        if (!m_halt) begin
            case (op)
                0: ;
                1: if (ins[23:12] == 12'd0) m_err[1] = 1'b1;
                2: begin
                    if (ins[27]) begin
                        m_samp = imm;
`ifdef CIRC_ADDR_EN
                        m_base = imm;
`endif
                    end else begin
                        m_coef = imm;
                    end
                end
                3: begin
`ifdef CIRC_ADDR_EN
                    if (ins[27]) m_len = imm;
`endif
                end
                4: begin
                    did_mac = 1'b1;
                    m_coef  = (m_coef + 1) & 16'hFFFF;
                    m_samp  = samp_after(m_samp);
                end
                5: r.clr = 1'b1;
                6: r.owe = 1'b1;
                7: m_halt = 1'b1;
                default: m_err[0] = 1'b1;
            endcase
        end
        r.mac    = did_mac;
        r.coef   = did_mac ? 16'(old_coef) : 16'(m_coef);
        r.samp   = did_mac ? 16'(old_samp) : 16'(m_samp);
        r.halted = m_halt;
        r.err    = m_err;
        comb_q.push_back(c);
        reg_q.push_back(r);
        n_issued++;
    endtask

    // Asynchronous reset asserted mid-cycle, with a LOOP word on the bus to show loop_we is forced low.
    task automatic do_reset();
        @(negedge clk);
        #2;
        bus.instr = 32'h1000_5003;
        reset     = 1'b0;
        reg_q.delete();
        comb_q.delete();
        pend_valid = 1'b0;
        model_reset();
        #1;
        check("rst_halted",  32'(bus.halted),    32'd0);
        check("rst_loop_we", 32'(bus.loop_we),   32'd0);
        check("rst_mac_en",  32'(bus.mac_en),    32'd0);
        check("rst_acc_clr", 32'(bus.acc_clr),   32'd0);
        check("rst_out_we",  32'(bus.out_we),    32'd0);
        check("rst_coef",    32'(bus.coef_addr), 32'd0);
        check("rst_samp",    32'(bus.samp_addr), 32'd0);
        check("rst_err",     32'(bus.err),       32'd0);
        bus.instr = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  op;
        int          r;
        w = $urandom();
        r = $urandom_range(0, 99);
        if      (r < 35) op = 4'h4;
        else if (r < 45) op = 4'h2;
        else if (r < 55) op = 4'h3;
        else if (r < 65) op = 4'h1;
        else if (r < 72) op = 4'h5;
        else if (r < 79) op = 4'h6;
        else if (r < 86) op = 4'h0;
        else             op = 4'($urandom_range(8, 15));
        w[31:28] = op;
        if (op == 4'h2) begin
            w[15:0] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                  : 16'($urandom_range(0, 64));
        end
        if (op == 4'h3) w[15:0] = 16'($urandom_range(0, 6));
        if (op == 4'h1 && $urandom_range(0, 3) == 0) w[23:12] = 12'd0;
        return w;
    endfunction

    // Monitor: registered results of instruction N are compared one cycle after its loop outputs.
    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                check($sformatf("mac_en[%0d]", pend.idx),    32'(bus.mac_en),    32'(pend.mac));
                check($sformatf("acc_clr[%0d]", pend.idx),   32'(bus.acc_clr),   32'(pend.clr));
                check($sformatf("out_we[%0d]", pend.idx),    32'(bus.out_we),    32'(pend.owe));
                check($sformatf("coef_addr[%0d]", pend.idx), 32'(bus.coef_addr), 32'(pend.coef));
                check($sformatf("samp_addr[%0d]", pend.idx), 32'(bus.samp_addr), 32'(pend.samp));
                check($sformatf("halted[%0d]", pend.idx),    32'(bus.halted),    32'(pend.halted));
                check($sformatf("err[%0d]", pend.idx),       32'(bus.err),       32'(pend.err));
                pend_valid = 1'b0;
            end
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                check($sformatf("loop_we[%0d]", c.idx),   32'(bus.loop_we),   32'(c.lwe));
                check($sformatf("loop_iter[%0d]", c.idx), 32'(bus.loop_iter), 32'(c.iter));
                check($sformatf("loop_size[%0d]", c.idx), 32'(bus.loop_size), 32'(c.size));
            end
            if (reg_q.size() > 0) begin
                pend       = reg_q.pop_front();
                pend_valid = 1'b1;
            end
        end
    end

    initial begin
        reset      = 1'b0;
        bus.instr  = 32'h0;
        pend_valid = 1'b0;
        model_reset();
        do_reset();

        // Idle after reset
        repeat (4) issue(32'h0000_0000);

        // Loop setup, then zero-iteration loop
        issue(32'h1000_5003);
        issue(32'h0000_0000);
        issue(32'h1000_0002);
        issue(32'h0000_0000);

        // Pointer setup and back-to-back MACs
        issue(32'h2000_0100);
        issue(32'h2800_0200);
        repeat (3) issue(32'h4000_0000);
        issue(32'h0000_0000);

        // Circular sample window (linear when built without it)
        issue(32'h2800_0010);
        issue(32'h3800_0004);
        repeat (6) issue(32'h4000_0000);
        issue(32'h0000_0000);

        // Pulses and illegal opcode
        issue(32'h5000_0000);
        issue(32'h6000_0000);
        issue(32'hA000_0000);
        issue(32'h0000_0000);

        // Halt, then ignored LOOP/MAC, then reset mid-halt and resume
        issue(32'h7000_0000);
        issue(32'h1000_5003);
        issue(32'h4000_0000);
        issue(32'hF000_0000);
        do_reset();
        issue(32'h2000_0040);
        issue(32'h4000_0000);
        issue(32'h0000_0000);

        // Random streams, each ended by a halt and a reset
        for (int round = 0; round < 4; round++) begin
            for (int k = 0; k < 120; k++) issue(rand_instr());
            issue(32'h7000_0000);
            repeat (3) issue(rand_instr());
            do_reset();
        end

        repeat (3) @(negedge clk);
        #1;
        check("drain", 32'(reg_q.size() + comb_q.size() + int'(pend_valid)), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage between program memory and the program sequencer.
- Takes the instruction word fetched at the sequencer's current `addr`.
- Issues the loop-setup write (`we`/`iter`/`size`) back to the sequencer in the same cycle.
- Drives registered FIR datapath controls: MAC enable, accumulator clear, output store.
- Holds two address generators (coefficient and sample pointers); the sample pointer supports circular addressing.

Parameters:
- PW, 16, width of the coefficient and sample pointers.
- OPW, 4, opcode field width; fixed at instr[31:28]. Not for override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- instr  input  32  instruction word read combinationally from program memory at the sequencer's `addr`.
- loop_we  output  1  combinational loop-setup write to the sequencer.
- loop_iter  output  12  combinational; instr[23:12].
- loop_size  output  12  combinational; instr[11:0].
- mac_en  output  1  registered; one multiply-accumulate this cycle.
- acc_clr  output  1  registered; clear accumulator.
- out_we  output  1  registered; store accumulator to output.
- coef_addr  output  PW  registered coefficient pointer.
- samp_addr  output  PW  registered sample pointer.
- halted  output  1  registered; block is in HALT state.
- err  output  2  sticky error flags: [0] illegal opcode, [1] LOOP with zero iterations.

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs, pointers, bases, lengths and `err` go to 0; state goes to RUN.
  - `loop_we` is forced to 0 while reset=0.
- Opcodes (instr[31:28]); each is actioned only in RUN:
  - 0x0 NOP: no action.
  - 0x1 LOOP:
    - `loop_we`=1 combinationally in the same cycle; `loop_iter`/`loop_size` always reflect instr[23:12]/instr[11:0].
    - If instr[23:12]==0, set err[1]; `loop_we` still asserted (the sequencer's behaviour is the programmer's fault).
  - 0x2 SETP: instr[27]=0 loads coef base and `coef_addr` := instr[15:0]; instr[27]=1 loads samp base and `samp_addr` := instr[15:0].
  - 0x3 SETL: instr[27]=1 loads the sample circular length := instr[15:0]; instr[27]=0 is a NOP.
  - 0x4 MAC:
    - `mac_en`=1 in the next cycle; `coef_addr`/`samp_addr` presented that cycle are the operand addresses.
    - Pointers then post-increment.
    - `coef_addr` +1, wraps mod 2^PW.
    - `samp_addr` follows the circular rule.
  - 0x5 CLR: `acc_clr`=1 in the next cycle.
  - 0x6 STORE: `out_we`=1 in the next cycle.
  - 0x7 HALT: next state HALT; `halted`=1 the next cycle.
  - 0x8-0xF: treated as NOP; sets err[0].
- Latency: `loop_we` is 0-cycle (combinational); all other controls are 1 cycle after the instruction is present. `mac_en`, `acc_clr` and `out_we` are single-cycle pulses.
- Circular rule (sample pointer): if length==0, linear +1. Otherwise, if `samp_addr`==base+length-1 (PW-bit arithmetic), next = base, else +1.
- Pointer timing:
  - MAC increments the pointers in the same edge that raises `mac_en`.
  - The operand address is the pre-increment value, held in a pipeline register.
  - So `coef_addr`/`samp_addr` equal the operand addresses while `mac_en`=1 and update on the following edge.
- FSM: RUN -> HALT on opcode 0x7. HALT is left only by reset.
  - In HALT: `loop_we`=0, no pulses, pointers frozen, and no error flags are set.
- Back-to-back MACs: one per cycle; no bubbles.
- `err` bits are sticky until reset.

Optional Feature:
- Macro CIRC_ADDR_EN.
- Defined: SETL and circular sample addressing behave as above.
- Undefined: SETL decodes as a legal NOP (no error); `samp_addr` always increments linearly mod 2^PW; the length register is not built.

Test Plan:
- Reset release, instr=0 for 4 cycles -> all outputs 0, `halted`=0, `err`=0.
- instr=0x1_005_003 -> same cycle `loop_we`=1, `loop_iter`=5, `loop_size`=3; next cycle `loop_we` follows new instr. instr=0x1_000_002 -> err[1]=1 and stays 1.
- SETP coef 0x0100, SETP samp 0x0200, 3×MAC -> `mac_en` high 3 cycles with (coef,samp)=(0x100,0x200),(0x101,0x201),(0x102,0x202).
- CIRC_ADDR_EN: SETP samp 0x10, SETL 4, 6×MAC -> samp operands 0x10,0x11,0x12,0x13,0x10,0x11. Without the macro -> 0x10..0x15.
- CLR, STORE, opcode 0xA -> `acc_clr` then `out_we` single-cycle pulses; err[0]=1.
- HALT then LOOP/MAC -> `halted`=1, `loop_we`=0, `mac_en`=0. Assert reset mid-HALT -> `halted`=0 asynchronously, RUN resumes.
